// File: rtl/long_mul_pkg.sv
// Shared constants for the shift-add multiply-accumulate block: FSM state
// encodings and default operand width.
package long_mul_pkg;

  localparam int DEFAULT_W     = 12;
  localparam int DEFAULT_IDX_W = $clog2(DEFAULT_W) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/long_multiplication_v1_0_two_abs.sv
// Two's complement magnitude/sign split for the signed build; the module only
// exists when LONG_MUL_SIGNED_EN is defined.
`ifdef LONG_MUL_SIGNED_EN
module two_abs #(
  parameter int width = 12
) (
  input  logic [width-1:0] value,
  output logic [width-1:0] magnitude,
  output logic             negative
);

  // The most negative input maps onto itself, which read unsigned is exactly its magnitude.
  assign negative  = value[width-1];
  assign magnitude = negative ? (~value + width'(1)) : value;

endmodule
`endif

// File: rtl/long_multiplication_v1_0.sv
// Sequential shift-add multiply-accumulate: product = multiplicand*multiplier + addend,
// one multiplier bit per two clocks. Define LONG_MUL_SIGNED_EN for two's complement operands.
module long_multiplication_v1_0
  import long_mul_pkg::*;
#(
  parameter int inout_width = DEFAULT_W
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic [inout_width-1:0]   multiplicand,
  input  logic [inout_width-1:0]   multiplier,
  input  logic [inout_width-1:0]   addend,
  input  logic                     data_valid,
  output logic [2*inout_width-1:0] product,
  output logic [inout_width-1:0]   result,
  output logic                     overflow,
  output logic                     data_ready,
  output logic                     busy
);

  localparam int W     = inout_width;
  localparam int IDX_W = $clog2(W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  logic [2:0]       state, state_nxt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     b_shr;
  logic [IDX_W-1:0] index;
  logic [W-1:0]     a_load;
  logic [W-1:0]     b_load;
  logic [2*W-1:0]   acc_load;
  logic             acc_overflow;

  logic idle_en, accept_en, add_en, shift_en, done_en;

`ifdef LONG_MUL_SIGNED_EN
  logic [W-1:0] a_mag, b_mag, c_reg;
  logic         a_neg, b_neg, sign_reg, fix_en;

  two_abs #(.width(W)) u_abs_a (.value(multiplicand), .magnitude(a_mag), .negative(a_neg));
  two_abs #(.width(W)) u_abs_b (.value(multiplier),   .magnitude(b_mag), .negative(b_neg));

  // Magnitudes are multiplied; the sign and the addend are applied in FIX.
  assign a_load       = a_mag;
  assign b_load       = b_mag;
  assign acc_load     = '0;
  assign acc_overflow = (acc != {{W{acc[W-1]}}, acc[W-1:0]});
`else
  assign a_load       = multiplicand;
  assign b_load       = multiplier;
  assign acc_load     = {{W{1'b0}}, addend};
  assign acc_overflow = (acc[2*W-1:W] != '0);
`endif

  assign b_shr = b_reg >> index;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (data_valid) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (index == LAST_IDX) begin
`ifdef LONG_MUL_SIGNED_EN
          state_nxt = S_FIX;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_ADD;
        end
      end
`ifdef LONG_MUL_SIGNED_EN
      S_FIX:   state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every strobe gets a default before the case so no latch is inferred.
  always_comb begin
    idle_en   = 1'b0;
    accept_en = 1'b0;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    done_en   = 1'b0;
`ifdef LONG_MUL_SIGNED_EN
    fix_en    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        idle_en   = 1'b1;
        accept_en = data_valid;
      end
      S_ADD:   add_en   = 1'b1;
      S_SHIFT: shift_en = 1'b1;
`ifdef LONG_MUL_SIGNED_EN
      S_FIX:   fix_en   = 1'b1;
`endif
      S_DONE:  done_en  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      acc        <= '0;
      mcand      <= '0;
      b_reg      <= '0;
      index      <= '0;
      product    <= '0;
      result     <= '0;
      overflow   <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
`ifdef LONG_MUL_SIGNED_EN
      c_reg      <= '0;
      sign_reg   <= 1'b0;
`endif
    end else begin
      if (idle_en) data_ready <= 1'b0;

      if (accept_en) begin
        acc   <= acc_load;
        mcand <= {{W{1'b0}}, a_load};
        b_reg <= b_load;
        index <= '0;
        busy  <= 1'b1;
`ifdef LONG_MUL_SIGNED_EN
        c_reg    <= addend;
        sign_reg <= a_neg ^ b_neg;
`endif
      end

      // Partial products fit in 2W bits, so the add never carries out.
      if (add_en && b_shr[0]) acc <= acc + mcand;

      if (shift_en) begin
        mcand <= mcand << 1;
        index <= index + IDX_W'(1);
      end

`ifdef LONG_MUL_SIGNED_EN
      if (fix_en) acc <= (sign_reg ? -acc : acc) + {{W{c_reg[W-1]}}, c_reg};
`endif

      if (done_en) begin
        product    <= acc;
        result     <= acc[W-1:0];
        overflow   <= acc_overflow;
        data_ready <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_long_multiplication_v1_0.sv
// Directed-vector bench for long_multiplication_v1_0 at W=12; the signed vectors
// replace the full-scale unsigned vector when LONG_MUL_SIGNED_EN is defined.
module tb_long_multiplication_v1_0;

  localparam int W      = 12;
  localparam int BUDGET = 100;
`ifdef LONG_MUL_SIGNED_EN
  localparam int LAT = 2 * W + 2;
`else
  localparam int LAT = 2 * W + 1;
`endif

  logic           aclk = 1'b0;
  logic           resetn = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [W-1:0]   addend = '0;
  logic           data_valid = 1'b0;
  logic [2*W-1:0] product;
  logic [W-1:0]   result;
  logic           overflow;
  logic           data_ready;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  long_multiplication_v1_0 #(.inout_width(W)) dut (
    .aclk        (aclk),
    .resetn      (resetn),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .addend      (addend),
    .data_valid  (data_valid),
    .product     (product),
    .result      (result),
    .overflow    (overflow),
    .data_ready  (data_ready),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  // Presents one operand set for exactly one rising edge; returns #1 after that edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    @(negedge aclk);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    data_valid   = 1'b1;
    @(posedge aclk);
    #1;
    data_valid = 1'b0;
  endtask

  // Counts rising edges until data_ready is seen; -1 when the budget runs out.
  task automatic wait_ready(output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < BUDGET) begin
      @(posedge aclk);
      #1;
      cycles++;
      if (data_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) cycles = -1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++; if (product !== 24'h0)  begin n_err++; $display("FAIL reset_product got %h want 000000", product); end
    n_vec++; if (result !== 12'h0)   begin n_err++; $display("FAIL reset_result got %h want 000", result); end
    n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge aclk);
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    start_op(12'd3, 12'd4, 12'd0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_after_accept got %b want 1", busy); end
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)          begin n_err++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'd12)  begin n_err++; $display("FAIL basic_product got %h want 00000c", product); end
    n_vec++; if (result !== 12'd12)   begin n_err++; $display("FAIL basic_result got %h want 00c", result); end
    n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL basic_overflow got %b want 0", overflow); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL basic_busy_at_ready got %b want 0", busy); end
    @(posedge aclk);
    #1;
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_pulse got %b want 0", data_ready); end
    n_vec++; if (product !== 24'd12)  begin n_err++; $display("FAIL basic_product_held got %h want 00000c", product); end
  endtask

  task automatic test_divider_inverse;
    int cyc;
    start_op(12'd33, 12'd37, 12'd14);
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)           begin n_err++; $display("FAIL inverse_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'h0004D3) begin n_err++; $display("FAIL inverse_product got %h want 0004d3", product); end
    n_vec++; if (result !== 12'h4D3)   begin n_err++; $display("FAIL inverse_result got %h want 4d3", result); end
    n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL inverse_overflow got %b want 0", overflow); end
  endtask

`ifndef LONG_MUL_SIGNED_EN
  task automatic test_full_scale;
    int cyc;
    start_op(12'hFFF, 12'hFFF, 12'hFFF);
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)             begin n_err++; $display("FAIL max_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'hFFF000) begin n_err++; $display("FAIL max_product got %h want fff000", product); end
    n_vec++; if (result !== 12'h000)     begin n_err++; $display("FAIL max_result got %h want 000", result); end
    n_vec++; if (overflow !== 1'b1)      begin n_err++; $display("FAIL max_overflow got %b want 1", overflow); end
  endtask
`else
  task automatic test_signed;
    int cyc;
    start_op(12'hFFD, 12'd5, 12'd2);
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)             begin n_err++; $display("FAIL signed_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'hFFFFF3) begin n_err++; $display("FAIL signed_product got %h want fffff3", product); end
    n_vec++; if (result !== 12'hFF3)     begin n_err++; $display("FAIL signed_result got %h want ff3", result); end
    n_vec++; if (overflow !== 1'b0)      begin n_err++; $display("FAIL signed_overflow got %b want 0", overflow); end
    start_op(12'h800, 12'h800, 12'h000);
    wait_ready(cyc);
    n_vec++; if (product !== 24'h400000) begin n_err++; $display("FAIL signed_min_product got %h want 400000", product); end
    n_vec++; if (result !== 12'h000)     begin n_err++; $display("FAIL signed_min_result got %h want 000", result); end
    n_vec++; if (overflow !== 1'b1)      begin n_err++; $display("FAIL signed_min_overflow got %b want 1", overflow); end
  endtask
`endif

  task automatic test_busy_ignore;
    int pulses;
    logic [2*W-1:0] got;
    pulses = 0;
    got    = '0;
    start_op(12'd0, 12'd2047, 12'd9);
    for (int i = 1; i <= 60; i++) begin
      @(negedge aclk);
      if (i == 3 || i == 10) begin
        multiplicand = 12'd5;
        multiplier   = 12'd5;
        addend       = 12'd1;
        data_valid   = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      @(posedge aclk);
      #1;
      if (data_ready === 1'b1) begin
        pulses++;
        got = product;
      end
    end
    data_valid = 1'b0;
    n_vec++; if (pulses != 1)   begin n_err++; $display("FAIL busy_ready_count got %0d want 1", pulses); end
    n_vec++; if (got !== 24'd9) begin n_err++; $display("FAIL busy_product got %h want 000009", got); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle_after got %b want 0", busy); end
  endtask

  task automatic test_abort;
    int cyc;
    int pulses;
    pulses = 0;
    start_op(12'd33, 12'd37, 12'd14);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b0;
    @(posedge aclk);
    #1;
    n_vec++; if (product !== 24'h0)   begin n_err++; $display("FAIL abort_product got %h want 000000", product); end
    n_vec++; if (result !== 12'h0)    begin n_err++; $display("FAIL abort_result got %h want 000", result); end
    n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL abort_overflow got %b want 0", overflow); end
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL abort_data_ready got %b want 0", data_ready); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge aclk);
    resetn = 1'b1;
    repeat (40) begin
      @(posedge aclk);
      #1;
      if (data_ready === 1'b1) pulses++;
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL abort_stray_ready got %0d want 0", pulses); end
    start_op(12'd100, 12'd3, 12'd7);
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)            begin n_err++; $display("FAIL abort_new_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'd307)   begin n_err++; $display("FAIL abort_new_product got %h want 000133", product); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_op(12'd7, 12'd9, 12'd0);
    wait_ready(cyc);
    n_vec++; if (product !== 24'd63) begin n_err++; $display("FAIL b2b_first_product got %h want 00003f", product); end
    // Operands presented in the data_ready cycle are taken at the very next edge.
    multiplicand = 12'd11;
    multiplier   = 12'd13;
    addend       = 12'd5;
    data_valid   = 1'b1;
    @(posedge aclk);
    #1;
    data_valid = 1'b0;
    n_vec++; if (busy !== 1'b1)       begin n_err++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_cleared got %b want 0", data_ready); end
    wait_ready(cyc);
    n_vec++; if (cyc != LAT)          begin n_err++; $display("FAIL b2b_latency got %0d want %0d", cyc, LAT); end
    n_vec++; if (product !== 24'd148) begin n_err++; $display("FAIL b2b_second_product got %h want 000094", product); end
    n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL b2b_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider_inverse();
`ifndef LONG_MUL_SIGNED_EN
    test_full_scale();
`else
    test_signed();
`endif
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
